// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store and load-extraction paths:
// access width codes and byte-lane enable generation.
package dm_store_buffer_pkg;

    localparam logic [1:0] DM_BYTE     = 2'b00;
    localparam logic [1:0] DM_HALFWORD = 2'b01;
    localparam logic [1:0] DM_WORD     = 2'b10;

    // Word accesses always enable all four lanes; narrower ones shift with the offset
    // and lose any lanes that fall past byte 3.
    function automatic logic [3:0] dm_lane_en(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] en;
        en = 4'b0000;
        case (width)
            DM_BYTE:     en = 4'b0001 << off;
            DM_HALFWORD: en = 4'b0011 << off;
            DM_WORD:     en = 4'b1111;
            default:     en = 4'b0000;
        endcase
        return en;
    endfunction

    function automatic logic dm_misaligned(input logic [1:0] width, input logic [1:0] off);
        return ((width == DM_HALFWORD) && off[0]) || ((width == DM_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_store_align.sv
// Combinational store alignment: byte-lane enables, lane-shifted data and
// a misalignment flag from the low address bits and access width.
module dm_store_align
    import dm_store_buffer_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wea_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    assign wea_o      = dm_lane_en(width_i, off_i);
    assign wdata_o    = data_i << {off_i, 3'b000};
    assign misalign_o = dm_misaligned(width_i, off_i);

endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them and drains to data memory
// over req/ack; flags loads hitting a pending word. Trap option: DM_STORE_MISALIGN_TRAP_EN.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_width,
    input  logic          ld_check_valid,
    input  logic [AW-1:0] ld_check_addr,
    output logic          ld_hazard,
    output logic          dm_req,
    input  logic          dm_ack,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_wea,
    output logic [31:0]   dm_wdata,
    output logic          sb_empty
`ifdef DM_STORE_MISALIGN_TRAP_EN
    ,
    output logic          misalign_err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-3:0] addr_q  [DEPTH];
    logic [3:0]    wea_q   [DEPTH];
    logic [31:0]   wdata_q [DEPTH];

    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]  al_wea;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic        full, push_hs, enq, pop;

    dm_store_align u_align (
        .off_i      (st_addr[1:0]),
        .width_i    (st_width),
        .data_i     (st_data),
        .wea_o      (al_wea),
        .wdata_o    (al_wdata),
        .misalign_o (al_mis)
    );

    assign full     = (cnt_q == CW'(DEPTH));
    assign st_ready = !full;
    assign dm_req   = (cnt_q != '0);
    assign sb_empty = (cnt_q == '0);
    assign push_hs  = st_valid & st_ready;
    assign pop      = dm_req & dm_ack;

`ifdef DM_STORE_MISALIGN_TRAP_EN
    logic mis_q;

    assign enq          = push_hs & (st_width != 2'b11) & !al_mis;
    assign misalign_err = mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= push_hs & al_mis;
    end
`else
    logic unused_mis;

    assign enq        = push_hs & (st_width != 2'b11);
    assign unused_mis = al_mis;
`endif

    // Head entry drives memory straight from the storage mux, keeping dm_* stable under backpressure.
    assign dm_addr  = {addr_q[rd_q], 2'b00};
    assign dm_wea   = wea_q[rd_q];
    assign dm_wdata = wdata_q[rd_q];

    always_comb begin
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        wr_d  = enq ? wr_q + PW'(1) : wr_q;
        cnt_d = cnt_q;
        case ({enq, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_q]  <= st_addr[AW-1:2];
            wea_q[wr_q]   <= al_wea;
            wdata_q[wr_q] <= al_wdata;
        end
    end

    // An entry is live when its distance from the head is below the count.
    logic          unused_ld_off;
    logic [PW-1:0] rel;
    logic          hit;

    assign unused_ld_off = ^ld_check_addr[1:0];

    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - rd_q;
            if ((CW'(rel) < cnt_q) && (addr_q[i] == ld_check_addr[AW-1:2]))
                hit = 1'b1;
        end
    end

    assign ld_hazard = ld_check_valid & hit;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer (DEPTH=2, AW=32).
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_width;
    logic        ld_check_valid, ld_hazard;
    logic [31:0] ld_check_addr;
    logic        dm_req, dm_ack;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wea;
    logic        sb_empty;
`ifdef DM_STORE_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(2), .AW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_width       (st_width),
        .ld_check_valid (ld_check_valid),
        .ld_check_addr  (ld_check_addr),
        .ld_hazard      (ld_hazard),
        .dm_req         (dm_req),
        .dm_ack         (dm_ack),
        .dm_addr        (dm_addr),
        .dm_wea         (dm_wea),
        .dm_wdata       (dm_wdata),
        .sb_empty       (sb_empty)
`ifdef DM_STORE_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    // Stimulus helpers only drive; each test does its own checking.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        st_valid = 1'b1; st_addr = a; st_data = d; st_width = w;
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_width = 0;
        ld_check_valid = 1'b1; ld_check_addr = 32'h0; dm_ack = 0;
        repeat (2) @(negedge clk);
        total++; if (dm_req !== 1'b0)   begin bad++; $display("FAIL rst_dm_req got=%b exp=0", dm_req); end
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_sb_empty got=%b exp=1", sb_empty); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_st_ready got=%b exp=1", st_ready); end
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL rst_ld_hazard got=%b exp=0", ld_hazard); end
`ifdef DM_STORE_MISALIGN_TRAP_EN
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
`endif
        rst = 1'b0; ld_check_valid = 1'b0;
    endtask

    task automatic test_byte();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h1003; st_data = 32'h0000_00AB; st_width = 2'b00;
        #1;
        total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL byte_no_bypass got=%b exp=0", dm_req); end
        @(negedge clk);
        st_valid = 1'b0;
        total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL byte_req got=%b exp=1", dm_req); end
        total++; if (dm_addr !== 32'h1000) begin bad++; $display("FAIL byte_addr got=%h exp=00001000", dm_addr); end
        total++; if (dm_wea !== 4'b1000) begin bad++; $display("FAIL byte_wea got=%b exp=1000", dm_wea); end
        total++; if (dm_wdata !== 32'hAB00_0000) begin bad++; $display("FAIL byte_wdata got=%h exp=ab000000", dm_wdata); end
        pop_one();
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL byte_retire got=%b exp=1", sb_empty); end
    endtask

    task automatic test_halfword_word();
        push(32'h2002, 32'h0000_1234, 2'b01);
        total++; if (dm_wea !== 4'b1100) begin bad++; $display("FAIL half_wea got=%b exp=1100", dm_wea); end
        total++; if (dm_wdata !== 32'h1234_0000) begin bad++; $display("FAIL half_wdata got=%h exp=12340000", dm_wdata); end
        total++; if (dm_addr !== 32'h2000) begin bad++; $display("FAIL half_addr got=%h exp=00002000", dm_addr); end
        pop_one();
        push(32'h3000, 32'hDEAD_BEEF, 2'b10);
        total++; if (dm_wea !== 4'b1111) begin bad++; $display("FAIL word_wea got=%b exp=1111", dm_wea); end
        total++; if (dm_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word_wdata got=%h exp=deadbeef", dm_wdata); end
        pop_one();
        // Reserved width is accepted but dropped.
        push(32'h3100, 32'h1, 2'b11);
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL w11_drop got=%b exp=1", sb_empty); end
    endtask

    task automatic test_backpressure();
        push(32'h0100, 32'h1111_1111, 2'b10);
        push(32'h0204, 32'h2222_2222, 2'b10);
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", st_ready); end
        st_valid = 1'b1; st_addr = 32'h0308; st_data = 32'h3333_3333; st_width = 2'b10;
        repeat (3) @(negedge clk);
        total++; if (dm_addr !== 32'h0100) begin bad++; $display("FAIL bp_stable_addr got=%h exp=00000100", dm_addr); end
        total++; if (dm_wdata !== 32'h1111_1111) begin bad++; $display("FAIL bp_stable_data got=%h exp=11111111", dm_wdata); end
        dm_ack = 1'b1;
        #1;
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_pop got=%b exp=0", st_ready); end
        @(negedge clk);
        dm_ack = 1'b0; st_valid = 1'b0;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", st_ready); end
        total++; if (dm_addr !== 32'h0204) begin bad++; $display("FAIL bp_order_addr got=%h exp=00000204", dm_addr); end
        total++; if (dm_wdata !== 32'h2222_2222) begin bad++; $display("FAIL bp_order_data got=%h exp=22222222", dm_wdata); end
        pop_one();
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL bp_third_blocked got=%b exp=1", sb_empty); end
    endtask

    task automatic test_back_to_back();
        push(32'h0600, 32'h0000_0066, 2'b10);
        @(negedge clk);
        dm_ack = 1'b1;
        st_valid = 1'b1; st_addr = 32'h0700; st_data = 32'h0000_0077; st_width = 2'b10;
        @(negedge clk);
        dm_ack = 1'b0; st_valid = 1'b0;
        total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL b2b_req got=%b exp=1", dm_req); end
        total++; if (dm_addr !== 32'h0700) begin bad++; $display("FAIL b2b_addr got=%h exp=00000700", dm_addr); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", st_ready); end
        pop_one();
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h4004; st_data = 32'h0; st_width = 2'b10;
        ld_check_valid = 1'b1; ld_check_addr = 32'h4006;
        #1;
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_push_same got=%b exp=0", ld_hazard); end
        @(negedge clk);
        st_valid = 1'b0;
        total++; if (ld_hazard !== 1'b1) begin bad++; $display("FAIL hz_hit got=%b exp=1", ld_hazard); end
        ld_check_addr = 32'h4008; #1;
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_other_word got=%b exp=0", ld_hazard); end
        ld_check_addr = 32'h4006; ld_check_valid = 1'b0; #1;
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_no_valid got=%b exp=0", ld_hazard); end
        ld_check_valid = 1'b1; dm_ack = 1'b1; #1;
        total++; if (ld_hazard !== 1'b1) begin bad++; $display("FAIL hz_popping got=%b exp=1", ld_hazard); end
        @(negedge clk);
        dm_ack = 1'b0;
        total++; if (ld_hazard !== 1'b0) begin bad++; $display("FAIL hz_retired got=%b exp=0", ld_hazard); end
        ld_check_valid = 1'b0;
    endtask

    task automatic test_misalign();
`ifdef DM_STORE_MISALIGN_TRAP_EN
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h5001; st_data = 32'h0000_ABCD; st_width = 2'b01;
        #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%b exp=1", st_ready); end
        @(negedge clk);
        st_valid = 1'b0;
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL mis_not_queued got=%b exp=1", sb_empty); end
        @(negedge clk);
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%b exp=0", misalign_err); end
`else
        // Halfword at offset 3 keeps only its low byte in lane 3.
        push(32'h5003, 32'h0000_ABCD, 2'b01);
        total++; if (dm_wea !== 4'b1000) begin bad++; $display("FAIL mis_wea got=%b exp=1000", dm_wea); end
        total++; if (dm_wdata !== 32'hCD00_0000) begin bad++; $display("FAIL mis_wdata got=%h exp=cd000000", dm_wdata); end
        pop_one();
`endif
    endtask

    task automatic test_reset_mid();
        push(32'h0800, 32'h8, 2'b10);
        push(32'h0900, 32'h9, 2'b10);
        total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL rm_pre_req got=%b exp=1", dm_req); end
        @(negedge clk);
        rst = 1'b1; #1;
        total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", dm_req); end
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rm_empty got=%b exp=1", sb_empty); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", st_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rm_after got=%b exp=1", sb_empty); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_halfword_word();
        test_backpressure();
        test_back_to_back();
        test_hazard();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
